// File: rtl/hdr_byte_link.sv
// Host byte link: fetch header bytes over rq/rdy, run the hash core, stream the digest back.
// Latency: per byte >= SYNC_STAGES+3 cycles; rq falls one cycle after the synchronised rdy edge.
// Backpressure: the host paces every byte with rdy; an optional wait timeout aborts to IDLE.
`timescale 1ns/1ps
module hdr_byte_link #(
  parameter int HDR_BYTES    = 80,
  parameter int DIGEST_BYTES = 32,
  parameter int NONCE_SUB    = 0,
  parameter int DIGEST_REV   = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CYC  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      rdy,
  input  logic [7:0]                rx_byte,
  output logic [7:0]                addr_out,
  output logic                      rq,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic [HDR_BYTES*8-1:0]    hdr_out,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [DIGEST_BYTES*8-1:0] digest_in,
  input  logic [31:0]               nonce_in
);

  localparam int FETCH_N = (NONCE_SUB != 0) ? HDR_BYTES - 4 : HDR_BYTES;
  localparam logic [7:0]  LAST_IDX = 8'(FETCH_N - 1);
  localparam logic [7:0]  LAST_J   = 8'(DIGEST_BYTES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, LREQ, LGAP, CSTART, CWAIT, UREQ, UGAP} state_t;

  state_t                      state, state_n;
  logic [SYNC_STAGES-1:0]      start_sync, rdy_sync;
  logic                        start_prev, rdy_prev;
  logic                        start_evt, rdy_evt;
  logic [7:0]                  idx, j, dbyte;
  logic [31:0]                 wcnt;
  logic                        expired, timeout;
  logic [DIGEST_BYTES*8-1:0]   dig_q;

  // Synchronise the asynchronous host strobes and keep the previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      rdy_sync   <= '0;
      start_prev <= 1'b0;
      rdy_prev   <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start};
      rdy_sync   <= {rdy_sync[SYNC_STAGES-2:0], rdy};
      start_prev <= start_sync[SYNC_STAGES-1];
      rdy_prev   <= rdy_sync[SYNC_STAGES-1];
    end
  end

  // Only rising edges matter, and a rdy edge counts only while a request is outstanding.
  assign start_evt = start_sync[SYNC_STAGES-1] & ~start_prev;
  assign rdy_evt   = rdy_sync[SYNC_STAGES-1] & ~rdy_prev & rq;
  assign expired   = (TIMEOUT_CYC > 0) && (wcnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; an answered request wins over a timeout on the same cycle.
  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      IDLE:   if (start_evt) state_n = LREQ;
      LREQ:   if (rdy_evt) state_n = LGAP;
              else if (expired) begin state_n = IDLE; timeout = 1'b1; end
      LGAP:   state_n = (idx == LAST_IDX) ? CSTART : LREQ;
      CSTART: state_n = CWAIT;
      CWAIT:  if (core_done) state_n = UREQ;
      UREQ:   if (rdy_evt) state_n = UGAP;
              else if (expired) begin state_n = IDLE; timeout = 1'b1; end
      UGAP:   state_n = (j == LAST_J) ? IDLE : UREQ;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: registered handshake outputs, counters, header and digest storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq      <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      idx     <= '0;
      j       <= '0;
      wcnt    <= '0;
      hdr_out <= '0;
      dig_q   <= '0;
    end else begin
      rq   <= (state_n == LREQ) || (state_n == UREQ);
      done <= (state_n == UREQ) || (state_n == UGAP);
      err  <= timeout;
      wcnt <= ((state == LREQ || state == UREQ) && state_n == state) ? wcnt + 32'd1 : 32'd0;
      case (state)
        IDLE: if (start_evt) idx <= '0;
        LREQ: if (rdy_evt) begin
          for (int k = 0; k < HDR_BYTES; k++)
            if (idx == 8'(k)) hdr_out[(HDR_BYTES-1-k)*8 +: 8] <= rx_byte;
        end
        LGAP: begin
          if (idx == LAST_IDX) begin
            // Nonce byte k lands in header byte HDR_BYTES-4+k, i.e. the tail of the bus.
            if (NONCE_SUB != 0)
              for (int k = 0; k < 4; k++) hdr_out[(3-k)*8 +: 8] <= nonce_in[8*k +: 8];
          end else begin
            idx <= idx + 8'd1;
          end
        end
        CWAIT: if (core_done) begin
          dig_q <= digest_in;
          j     <= '0;
        end
        UGAP: if (j != LAST_J) j <= j + 8'd1;
        default: ;
      endcase
    end
  end

  // Pick digest byte j, counted from the MS end unless the reverse order is selected.
  always_comb begin
    dbyte = 8'd0;
    for (int k = 0; k < DIGEST_BYTES; k++)
      if (j == 8'(k))
        dbyte = (DIGEST_REV != 0) ? dig_q[k*8 +: 8] : dig_q[(DIGEST_BYTES-1-k)*8 +: 8];
  end

  // Address/data bus and status decode.
  always_comb begin
    addr_out = 8'd0;
    case (state)
      LREQ, LGAP: addr_out = idx;
      UREQ, UGAP: addr_out = dbyte;
      default:    addr_out = 8'd0;
    endcase
  end

  assign busy       = (state != IDLE);
  assign core_start = (state == CSTART);

endmodule
